cache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache controller.
- Sequences three memc arrays (valid: Size=1, tag: Size=TAG_W, data: Size=DATA_W), all sharing one 9-bit index.
- Sits between the CPU load/store port and the main-memory handshake port; stalls the CPU on misses and on every write.
- Keeps saturating hit/miss counters for performance labs.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_ctrl_if.sv | 26 ++
 rtl/cache_ctrl_sat_counter.sv | 20 ++
 rtl/cache_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field constants for the direct-mapped cache controller.
package cache_pkg;

    localparam int unsigned INDEX_W = 9;

    // Word address layout: [INDEX_W-1:0] index, tag above it.
    localparam int unsigned IDX_LSB = 0;
    localparam int unsigned IDX_MSB = INDEX_W - 1;
    localparam int unsigned TAG_LSB = INDEX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        FILL    = 2'd2,
        WR_MEM  = 2'd3
    } state_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// Main-memory request/ready handshake between the cache controller and memory.
interface cache_ctrl_if
    import cache_pkg::*;
#(
    parameter int unsigned TAG_W  = 7,
    parameter int unsigned DATA_W = 32
) ();

    logic                     mem_rd;
    logic                     mem_wr;
    logic [TAG_W+INDEX_W-1:0] mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     mem_ready;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/cache_ctrl_sat_counter.sv
// Saturating up-counter used for the hit/miss statistics.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller driving
// external valid/tag/data arrays (async read, negedge write) and a memory handshake.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned TAG_W  = 7,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_rd,
    input  logic                     cpu_wr,
    input  logic [TAG_W+INDEX_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_stall,
    output logic [INDEX_W-1:0]       c_index,
    input  logic                     valid_rdata,
    input  logic [TAG_W-1:0]         tag_rdata,
    input  logic [DATA_W-1:0]        data_rdata,
    output logic                     valid_we,
    output logic                     tag_we,
    output logic                     data_we,
    output logic                     valid_wdata,
    output logic [TAG_W-1:0]         tag_wdata,
    output logic [DATA_W-1:0]        data_wdata,
    cache_ctrl_if.master             mem,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);

    state_t                   state;
    state_t                   state_nxt;
    logic [TAG_W+INDEX_W-1:0] addr_q;
    logic [DATA_W-1:0]        data_q;
    logic [TAG_W-1:0]         cur_tag;
    logic                     hit;
    logic                     hit_inc;
    logic                     miss_inc;

    // Array index and tag under comparison: live CPU address in IDLE, latched otherwise.
    always_comb begin
        if (state == IDLE) begin
            c_index = cpu_addr[IDX_MSB:IDX_LSB];
            cur_tag = cpu_addr[TAG_LSB +: TAG_W];
        end else begin
            c_index = addr_q[IDX_MSB:IDX_LSB];
            cur_tag = addr_q[TAG_LSB +: TAG_W];
        end
        hit = valid_rdata && (tag_rdata == cur_tag);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_wr) begin
                    state_nxt = WR_MEM;
                end else if (cpu_rd && !hit) begin
                    state_nxt = RD_MISS;
                end
            end
            RD_MISS: if (mem.mem_ready) state_nxt = FILL;
            FILL:    state_nxt = IDLE;
            WR_MEM:  if (mem.mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latched address and data: store data on a write, fill data on a read miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wr) begin
                        addr_q <= cpu_addr;
                        data_q <= cpu_wdata;
                    end else if (cpu_rd && !hit) begin
                        addr_q <= cpu_addr;
                    end
                end
                RD_MISS: if (mem.mem_ready) data_q <= mem.mem_rdata;
                default: ;
            endcase
        end
    end

    // Outputs; everything is forced quiet while rst is high so no array write lands in a reset cycle.
    always_comb begin
        cpu_rdata     = data_rdata;
        cpu_stall     = 1'b0;
        valid_we      = 1'b0;
        tag_we        = 1'b0;
        data_we       = 1'b0;
        valid_wdata   = 1'b0;
        tag_wdata     = addr_q[TAG_LSB +: TAG_W];
        data_wdata    = (state == FILL) ? data_q : cpu_wdata;
        mem.mem_rd    = 1'b0;
        mem.mem_wr    = 1'b0;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = data_q;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (cpu_wr) begin
                        cpu_stall = 1'b1;
                        data_we   = hit;
                    end else if (cpu_rd) begin
                        if (hit) begin
                            hit_inc = 1'b1;
                        end else begin
                            cpu_stall = 1'b1;
                            miss_inc  = 1'b1;
                        end
                    end
                end
                RD_MISS: begin
                    mem.mem_rd = 1'b1;
                    cpu_stall  = 1'b1;
                end
                FILL: begin
                    valid_we    = 1'b1;
                    tag_we      = 1'b1;
                    data_we     = 1'b1;
                    valid_wdata = 1'b1;
                    cpu_stall   = 1'b1;
                end
                WR_MEM: begin
                    mem.mem_wr = 1'b1;
                    cpu_stall  = !mem.mem_ready;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_cnt)
    );

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: behavioural memc arrays plus a hand-driven memory port;
// a second, narrow-counter instance exercises counter saturation.
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [8:0]  c_index;
    logic        valid_rdata;
    logic [6:0]  tag_rdata;
    logic [31:0] data_rdata;
    logic        valid_we;
    logic        tag_we;
    logic        data_we;
    logic        valid_wdata;
    logic [6:0]  tag_wdata;
    logic [31:0] data_wdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    logic        v_arr [512];
    logic [6:0]  t_arr [512];
    logic [31:0] d_arr [512];

    int n_cmp;
    int n_bad;

    cache_ctrl_if #(.TAG_W(7), .DATA_W(32)) mif ();
    cache_ctrl_if #(.TAG_W(7), .DATA_W(32)) mif2 ();

    cache_ctrl #(.TAG_W(7), .DATA_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .c_index     (c_index),
        .valid_rdata (valid_rdata),
        .tag_rdata   (tag_rdata),
        .data_rdata  (data_rdata),
        .valid_we    (valid_we),
        .tag_we      (tag_we),
        .data_we     (data_we),
        .valid_wdata (valid_wdata),
        .tag_wdata   (tag_wdata),
        .data_wdata  (data_wdata),
        .mem         (mif),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    // Second instance: never-valid cache, zero-wait memory, 3-bit counters.
    logic [31:0] rdata2;
    logic        stall2;
    logic [8:0]  idx2;
    logic        vwe2;
    logic        twe2;
    logic        dwe2;
    logic        vwd2;
    logic [6:0]  twd2;
    logic [31:0] dwd2;
    logic [2:0]  hit_cnt2;
    logic [2:0]  miss_cnt2;

    assign mif2.mem_ready = mif2.mem_rd;
    assign mif2.mem_rdata = 32'h0;

    cache_ctrl #(.TAG_W(7), .DATA_W(32), .CNT_W(3)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .cpu_rd      (1'b1),
        .cpu_wr      (1'b0),
        .cpu_addr    (16'h0003),
        .cpu_wdata   (32'h0),
        .cpu_rdata   (rdata2),
        .cpu_stall   (stall2),
        .c_index     (idx2),
        .valid_rdata (1'b0),
        .tag_rdata   (7'h0),
        .data_rdata  (32'h0),
        .valid_we    (vwe2),
        .tag_we      (twe2),
        .data_we     (dwe2),
        .valid_wdata (vwd2),
        .tag_wdata   (twd2),
        .data_wdata  (dwd2),
        .mem         (mif2),
        .hit_cnt     (hit_cnt2),
        .miss_cnt    (miss_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memc model: asynchronous read, negedge write, reset clears the valid bits.
    assign valid_rdata = v_arr[c_index];
    assign tag_rdata   = t_arr[c_index];
    assign data_rdata  = d_arr[c_index];

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) v_arr[i] <= 1'b0;
        end else begin
            if (valid_we) v_arr[c_index] <= valid_wdata;
            if (tag_we)   t_arr[c_index] <= tag_wdata;
            if (data_we)  d_arr[c_index] <= data_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_addr = 16'h0;
        cpu_wdata = 32'h0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'h0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_hit_cnt", 32'(hit_cnt), 32'h0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'h0);
        chk("rst_stall", 32'(cpu_stall), 32'h0);
        chk("rst_mem_rd", 32'(mif.mem_rd), 32'h0);

        // Cold load of 0x0005: miss, latency-3 memory, fill, then hit
        cpu_rd = 1'b1;
        cpu_addr = 16'h0005;
        #1;
        chk("miss1_stall", 32'(cpu_stall), 32'h1);
        chk("miss1_index", 32'(c_index), 32'h5);
        step();
        chk("miss1_cnt", 32'(miss_cnt), 32'h1);
        chk("miss1_mem_rd", 32'(mif.mem_rd), 32'h1);
        chk("miss1_mem_addr", 32'(mif.mem_addr), 32'h5);
        step();
        chk("miss1_mem_rd_held", 32'(mif.mem_rd), 32'h1);
        step();
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 32'hDEADBEEF;
        step();
        mif.mem_ready = 1'b0;
        #1;
        chk("fill1_valid_we", 32'(valid_we), 32'h1);
        chk("fill1_tag_we", 32'(tag_we), 32'h1);
        chk("fill1_data_we", 32'(data_we), 32'h1);
        chk("fill1_data", data_wdata, 32'hDEADBEEF);
        chk("fill1_tag", 32'(tag_wdata), 32'h0);
        chk("fill1_index", 32'(c_index), 32'h5);
        chk("fill1_mem_rd", 32'(mif.mem_rd), 32'h0);
        step();
        chk("hit1_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("hit1_stall", 32'(cpu_stall), 32'h0);
        step();
        chk("hit1_cnt", 32'(hit_cnt), 32'h1);

        // Repeat load hits in the same cycle
        #1;
        chk("hit2_stall", 32'(cpu_stall), 32'h0);
        chk("hit2_mem_rd", 32'(mif.mem_rd), 32'h0);
        chk("hit2_rdata", cpu_rdata, 32'hDEADBEEF);
        step();
        chk("hit2_cnt", 32'(hit_cnt), 32'h2);

        // Alias 0x0205 evicts index 5 (zero-wait memory)
        cpu_addr = 16'h0205;
        #1;
        chk("alias_stall", 32'(cpu_stall), 32'h1);
        step();
        chk("alias_miss_cnt", 32'(miss_cnt), 32'h2);
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 32'h11111111;
        step();
        mif.mem_ready = 1'b0;
        #1;
        chk("alias_fill_tag", 32'(tag_wdata), 32'h1);
        step();
        chk("alias_hit_rdata", cpu_rdata, 32'h11111111);
        step();
        chk("alias_hit_cnt", 32'(hit_cnt), 32'h3);
        cpu_addr = 16'h0005;
        #1;
        chk("evicted_stall", 32'(cpu_stall), 32'h1);
        step();
        chk("evicted_miss_cnt", 32'(miss_cnt), 32'h3);
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 32'hDEADBEEF;
        step();
        mif.mem_ready = 1'b0;
        step();
        chk("refill_rdata", cpu_rdata, 32'hDEADBEEF);
        step();

        // Store hit to 0x0005: array write in IDLE, then write-through
        cpu_rd = 1'b0;
        cpu_wr = 1'b1;
        cpu_wdata = 32'hCAFEF00D;
        #1;
        chk("wrhit_stall", 32'(cpu_stall), 32'h1);
        chk("wrhit_data_we", 32'(data_we), 32'h1);
        chk("wrhit_data", data_wdata, 32'hCAFEF00D);
        chk("wrhit_valid_we", 32'(valid_we), 32'h0);
        chk("wrhit_mem_wr_idle", 32'(mif.mem_wr), 32'h0);
        step();
        chk("wrhit_mem_wr", 32'(mif.mem_wr), 32'h1);
        chk("wrhit_mem_addr", 32'(mif.mem_addr), 32'h5);
        chk("wrhit_mem_wdata", mif.mem_wdata, 32'hCAFEF00D);
        chk("wrhit_no_second_we", 32'(data_we), 32'h0);
        step();
        chk("wrhit_mem_wr_held", 32'(mif.mem_wr), 32'h1);
        mif.mem_ready = 1'b1;
        #1;
        chk("wrhit_done_stall", 32'(cpu_stall), 32'h0);
        step();
        mif.mem_ready = 1'b0;
        cpu_wr = 1'b0;
        cpu_rd = 1'b1;
        #1;
        chk("wrhit_load_stall", 32'(cpu_stall), 32'h0);
        chk("wrhit_load_rdata", cpu_rdata, 32'hCAFEF00D);
        chk("wrhit_hit_cnt", 32'(hit_cnt), 32'h4);
        chk("wrhit_miss_cnt", 32'(miss_cnt), 32'h3);
        step();
        chk("wrhit_load_cnt", 32'(hit_cnt), 32'h5);

        // Store miss to 0x0100: memory write only, no allocation
        cpu_rd = 1'b0;
        cpu_wr = 1'b1;
        cpu_addr = 16'h0100;
        cpu_wdata = 32'h12345678;
        #1;
        chk("wrmiss_data_we", 32'(data_we), 32'h0);
        chk("wrmiss_valid_we", 32'(valid_we), 32'h0);
        chk("wrmiss_tag_we", 32'(tag_we), 32'h0);
        step();
        chk("wrmiss_mem_wr", 32'(mif.mem_wr), 32'h1);
        chk("wrmiss_mem_rd", 32'(mif.mem_rd), 32'h0);
        chk("wrmiss_mem_addr", 32'(mif.mem_addr), 32'h100);
        mif.mem_ready = 1'b1;
        step();
        mif.mem_ready = 1'b0;
        cpu_wr = 1'b0;
        cpu_rd = 1'b1;
        #1;
        chk("wrmiss_load_stall", 32'(cpu_stall), 32'h1);
        step();
        chk("wrmiss_load_miss_cnt", 32'(miss_cnt), 32'h4);
        chk("wrmiss_load_mem_rd", 32'(mif.mem_rd), 32'h1);

        // Reset during RD_MISS abandons the fetch; a late mem_ready is ignored
        rst = 1'b1;
        cpu_rd = 1'b0;
        step();
        rst = 1'b0;
        mif.mem_ready = 1'b1;
        #1;
        chk("rstmid_mem_rd", 32'(mif.mem_rd), 32'h0);
        chk("rstmid_hit_cnt", 32'(hit_cnt), 32'h0);
        chk("rstmid_miss_cnt", 32'(miss_cnt), 32'h0);
        chk("rstmid_stall", 32'(cpu_stall), 32'h0);
        chk("rstmid_cnt2", 32'(miss_cnt2), 32'h0);
        step();
        mif.mem_ready = 1'b0;
        #1;
        chk("late_ready_mem_rd", 32'(mif.mem_rd), 32'h0);
        chk("late_ready_valid_we", 32'(valid_we), 32'h0);
        chk("late_ready_data_we", 32'(data_we), 32'h0);
        chk("sat_first_miss", 32'(miss_cnt2), 32'h1);

        // Narrow counter: 10 misses in 30 cycles must hold at all-ones
        for (int i = 0; i < 29; i++) step();
        chk("sat_miss_cnt", 32'(miss_cnt2), 32'h7);
        chk("sat_hit_cnt", 32'(hit_cnt2), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
